// File: rtl/fp_round_pack_if.sv
// fp_round_pack_if: handshake and data bundle between the normalizing shifter,
// the round/pack back end and FPU writeback.
//   in_*      : producer -> round/pack beat (valid/ready)
//   out_*     : round/pack -> writeback beat (valid/ready)
//   result    : packed IEEE-754 single {sign, exp, frac}
//   flags     : {overflow, underflow, inexact}
// master = producer/consumer side (testbench or surrounding FPU), slave = fp_round_pack.
interface fp_round_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [23:0] mant_in;
  logic [4:0]  shamt_in;
  logic [1:0]  rs_in;
  logic [1:0]  rm_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [2:0]  flags;

  modport master (
    output in_valid, sign_in, exp_in, mant_in, shamt_in, rs_in, rm_in, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, sign_in, exp_in, mant_in, shamt_in, rs_in, rm_in, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp_round_pack.sv
// fp_round_pack: single-precision add/sub back end after the leading-zero shifter.
// Stage 1 adjusts the exponent by the shift count and decides the rounding
// increment; stage 2 applies it, handles carry-out, overflow/underflow and packs
// the IEEE word. Two-stage valid/ready pipeline, 1 beat/clk, 2-cycle latency.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high; discards in-flight beats
//   bus   : fp_round_pack_if.slave (input beat, output beat, result, flags)
module fp_round_pack (
  input  logic              clk,
  input  logic              reset,
  fp_round_pack_if.slave    bus
);

  typedef struct packed {
    logic        sign;
    logic [23:0] mant;
    logic [9:0]  e;       // two's complement, exp_in - shamt_in
    logic        inc;
    logic        zero;
    logic [1:0]  rm;
    logic        rs_any;  // R|S: result is inexact unless flushed/zero
  } s1_t;

  s1_t         s1_q, s1_d, s1_new;
  logic        s1_valid_q, s1_valid_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_result_q, s2_result_d;
  logic [2:0]  s2_flags_q, s2_flags_d;

  logic        advance2, in_ready, accept, s1_move;

  // Stage 2 can take a beat when empty or when its beat leaves this edge.
  assign advance2 = ~s2_valid_q | bus.out_ready;
  assign in_ready = ~reset & (~s1_valid_q | advance2);
  assign accept   = bus.in_valid & in_ready;
  assign s1_move  = s1_valid_q & advance2;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.result    = s2_result_q;
  assign bus.flags     = s2_flags_q;

  // Stage 1 decode
  always_comb begin
    s1_new        = '0;
    s1_new.sign   = bus.sign_in;
    s1_new.mant   = bus.mant_in;
    s1_new.e      = {2'b00, bus.exp_in} - {5'b00000, bus.shamt_in};
    s1_new.zero   = (bus.mant_in == 24'd0);
    s1_new.rm     = bus.rm_in;
    s1_new.rs_any = |bus.rs_in;
    unique case (bus.rm_in)
      2'd0:    s1_new.inc = bus.rs_in[1] & (bus.rs_in[0] | bus.mant_in[0]);
      2'd1:    s1_new.inc = 1'b0;
      2'd2:    s1_new.inc = ~bus.sign_in & (|bus.rs_in);
      default: s1_new.inc = bus.sign_in & (|bus.rs_in);
    endcase
  end

  // Stage 2 round + pack
  logic [24:0]        m25;
  logic [22:0]        frac_r;
  logic signed [9:0]  e_r;
  logic               to_inf;

  always_comb begin
    m25    = {1'b0, s1_q.mant} + {24'd0, s1_q.inc};
    // Carry-out leaves 1.000..0, so the fraction is all zero and exp bumps.
    frac_r = m25[24] ? m25[23:1] : m25[22:0];
    e_r    = m25[24] ? $signed(s1_q.e) + 10'sd1 : $signed(s1_q.e);
    // Overflow goes to infinity only when the mode rounds away from zero.
    to_inf = (s1_q.rm == 2'd0) | ((s1_q.rm == 2'd2) & ~s1_q.sign) |
             ((s1_q.rm == 2'd3) & s1_q.sign);
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_flags_d  = s2_flags_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_d       = s1_new;
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end

    if (s1_move) begin
      s2_valid_d = 1'b1;
      if (s1_q.zero) begin
        s2_result_d = {s1_q.sign, 31'd0};
        s2_flags_d  = 3'b000;
      end else if (e_r <= 10'sd0) begin
        s2_result_d = {s1_q.sign, 31'd0};
        s2_flags_d  = 3'b011;
      end else if (e_r >= 10'sd255) begin
        s2_result_d = {s1_q.sign, to_inf ? 31'h7F80_0000 : 31'h7F7F_FFFF};
        s2_flags_d  = 3'b101;
      end else begin
        s2_result_d = {s1_q.sign, e_r[7:0], frac_r};
        s2_flags_d  = {2'b00, s1_q.rs_any};
      end
    end else if (advance2) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_flags_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_flags_q  <= s2_flags_d;
    end
  end

endmodule

// File: tb/tb_fp_round_pack.sv
// tb_fp_round_pack: directed and randomized checks of fp_round_pack against an
// arithmetic reference model and hand-computed expected words.
module tb_fp_round_pack;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fp_round_pack_if bus();
  fp_round_pack dut (.clk(clk), .reset(reset), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  logic [34:0] exp_q[$];        // {flags, result} in issue order
  bit          hold_v = 1'b0;
  logic [34:0] hold_val = '0;
  bit          rnd_ready = 1'b0;

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: real rounding arithmetic on integers, then IEEE packing.
  function automatic logic [34:0] model(input logic s, input logic [7:0] ex,
      input logic [23:0] m, input logic [4:0] sh, input logic [1:0] rs, input logic [1:0] rm);
    int e, mm;
    bit up, inexact, to_inf;
    if (m == 24'd0) return {3'b000, s, 31'd0};
    e = int'(ex) - int'(sh);
    inexact = rs[1] | rs[0];
    case (rm)
      2'd0: up = rs[1] && (rs[0] || m[0]);
      2'd1: up = 1'b0;
      2'd2: up = !s && inexact;
      default: up = s && inexact;
    endcase
    mm = int'(m) + (up ? 1 : 0);
    if (mm >= (1 << 24)) begin mm = mm / 2; e = e + 1; end
    if (e <= 0) return {3'b011, s, 31'd0};
    if (e >= 255) begin
      to_inf = (rm == 2'd0) || (rm == 2'd2 && !s) || (rm == 2'd3 && s);
      return {3'b101, s, to_inf ? 31'h7F80_0000 : 31'h7F7F_FFFF};
    end
    return {2'b00, inexact, s, e[7:0], mm[22:0]};
  endfunction

  // Output monitor: scoreboard on transfer, stability while stalled.
  always @(negedge clk) begin
    #1;
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && bus.out_valid) chk("hold_stable", {bus.flags, bus.result}, hold_val);
      hold_v   = bus.out_valid && !bus.out_ready;
      hold_val = {bus.flags, bus.result};
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 35'(bus.out_valid), 35'd0);
        else chk("result", {bus.flags, bus.result}, exp_q.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic s, input logic [7:0] ex, input logic [23:0] m,
      input logic [4:0] sh, input logic [1:0] rs, input logic [1:0] rm, input logic [34:0] expv);
    int wn = 0;
    bus.in_valid = 1'b1; bus.sign_in = s; bus.exp_in = ex; bus.mant_in = m;
    bus.shamt_in = sh; bus.rs_in = rs; bus.rm_in = rm;
    #1;
    while (!bus.in_ready && wn < 200) begin
      @(negedge clk);
      if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      wn++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 35'(bus.in_ready), 35'd1);
    else begin
      @(posedge clk);
      exp_q.push_back(expv);
    end
    @(negedge clk);
  endtask

  task automatic send_m(input logic s, input logic [7:0] ex, input logic [23:0] m,
      input logic [4:0] sh, input logic [1:0] rs, input logic [1:0] rm);
    send(s, ex, m, sh, rs, rm, model(s, ex, m, sh, rs, rm));
  endtask

  task automatic drain();
    int n = 0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("drain_empty", 35'(exp_q.size()), 35'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic s;
    logic [7:0] ex;
    logic [23:0] m;
    logic [4:0] sh;
    bus.in_valid = 1'b0; bus.sign_in = 1'b0; bus.exp_in = '0; bus.mant_in = '0;
    bus.shamt_in = '0; bus.rs_in = '0; bus.rm_in = '0; bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 35'(bus.in_ready), 35'd0);
    chk("rst_out_valid", 35'(bus.out_valid), 35'd0);
    chk("rst_result_flags", {bus.flags, bus.result}, 35'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_in_ready", 35'(bus.in_ready), 35'd1);
    chk("post_rst_out_valid", 35'(bus.out_valid), 35'd0);
    @(negedge clk);

    // 1) basic pack and 2-cycle latency
    send(1'b0, 8'd129, 24'hC00000, 5'd2, 2'b00, 2'd0, {3'b000, 32'h3FC0_0000});
    bus.in_valid = 1'b0;
    #1;
    chk("latency_n", 35'(bus.out_valid), 35'd0);
    @(negedge clk);
    #1;
    chk("latency_n1", 35'(bus.out_valid), 35'd1);
    @(negedge clk);

    // 2)-5) directed rounding / boundary cases, back to back
    send(1'b0, 8'd127, 24'h800001, 5'd0, 2'b10, 2'd0, {3'b001, 32'h3F80_0002});
    send(1'b0, 8'd127, 24'h800000, 5'd0, 2'b10, 2'd0, {3'b001, 32'h3F80_0000});
    send(1'b0, 8'd127, 24'hFFFFFF, 5'd0, 2'b11, 2'd0, {3'b001, 32'h4000_0000});
    send(1'b0, 8'd127, 24'hFFFFFF, 5'd0, 2'b11, 2'd1, {3'b001, 32'h3FFF_FFFF});
    send(1'b0, 8'd254, 24'hFFFFFF, 5'd0, 2'b10, 2'd0, {3'b101, 32'h7F80_0000});
    send(1'b0, 8'd254, 24'hFFFFFF, 5'd0, 2'b10, 2'd1, {3'b001, 32'h7F7F_FFFF});
    send(1'b1, 8'd255, 24'h800000, 5'd0, 2'b00, 2'd2, {3'b101, 32'hFF7F_FFFF});
    send(1'b1, 8'd255, 24'h800000, 5'd0, 2'b00, 2'd3, {3'b101, 32'hFF80_0000});
    send(1'b0, 8'd255, 24'h800000, 5'd0, 2'b00, 2'd3, {3'b101, 32'h7F7F_FFFF});
    send(1'b0, 8'd3,   24'h800000, 5'd5, 2'b00, 2'd0, {3'b011, 32'h0000_0000});
    send(1'b1, 8'd3,   24'h000000, 5'd5, 2'b11, 2'd0, {3'b000, 32'h8000_0000});
    drain();

    // 6) stall: two held beats block input, then release and stream
    bus.out_ready = 1'b0;
    send_m(1'b0, 8'd100, 24'h812345, 5'd1, 2'b01, 2'd0);
    send_m(1'b1, 8'd140, 24'hABCDEF, 5'd3, 2'b10, 2'd0);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", 35'(bus.in_ready), 35'd0);
      chk("stall_out_valid", 35'(bus.out_valid), 35'd1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    send_m(1'b0, 8'd60, 24'hF00001, 5'd0, 2'b11, 2'd2);
    send_m(1'b1, 8'd200, 24'h900000, 5'd7, 2'b01, 2'd3);
    drain();

    // Reset with two beats in flight: nothing may come out afterwards
    bus.out_ready = 1'b0;
    send_m(1'b0, 8'd120, 24'hC00001, 5'd0, 2'b00, 2'd0);
    send_m(1'b0, 8'd121, 24'hC00002, 5'd0, 2'b00, 2'd0);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #1;
    chk("midrst_out_valid", 35'(bus.out_valid), 35'd0);
    chk("midrst_in_ready", 35'(bus.in_ready), 35'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("after_rst_quiet", 35'(bus.out_valid), 35'd0);
      @(negedge clk);
    end

    // Randomized stream with random back-pressure and gaps
    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      s = 1'(($urandom));
      m = ($urandom_range(0, 15) == 0) ? 24'd0 : {1'b1, 23'($urandom)};
      sh = (m == 24'd0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 23));
      case ($urandom_range(0, 3))
        0: ex = 8'($urandom_range(0, 30));
        1: ex = 8'($urandom_range(250, 255));
        default: ex = 8'($urandom);
      endcase
      send_m(s, ex, m, sh, 2'($urandom), 2'($urandom));
    end
    rnd_ready = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
